// File: rtl/pe_code_capture_pkg.sv
// rtl/pe_code_capture_pkg.sv - shared constants, entry layout and code legality check
package pe_pkg;
   localparam logic [7:0] CODE_NONE = 8'hF0;
   localparam int IDX_W = 4;
   localparam int TS_W_DFLT = 8;

   typedef struct packed {
      logic                 none;
      logic [IDX_W-1:0]     idx;
      logic [TS_W_DFLT-1:0] stamp;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic logic is_legal_code(input logic [7:0] code);
      return (code <= 8'd15) || (code == CODE_NONE);
   endfunction
endpackage

// File: rtl/pe_code_capture_if.sv
// rtl/pe_code_capture_if.sv - encoder code input and event stream output
interface pe_code_capture_if
   import pe_pkg::*;
#(
   parameter int TS_W = 8
);
   logic [7:0]          code_in;
   logic                in_en;
   logic                out_valid;
   logic                out_ready;
   logic [IDX_W+TS_W:0] out_data;

   modport master (output code_in, in_en, out_ready, input out_valid, out_data);
   modport slave  (input code_in, in_en, out_ready, output out_valid, out_data);
endinterface

// File: rtl/pe_code_capture_fifo.sv
// rtl/pe_code_capture_fifo.sv - first-word-fall-through FIFO for capture events
module sync_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && valid;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   assign rdata   = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/pe_code_capture.sv
// rtl/pe_code_capture.sv - time-stamps changes of the priority-encoder code into a FIFO
module pe_code_capture
   import pe_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TS_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   pe_code_capture_if.slave       bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic [7:0]             drop_cnt,
   output logic                   err,
   input  logic                   clr_flags
);
   localparam int EW = 1 + IDX_W + TS_W;

   logic [TS_W-1:0]  ts;
   logic [7:0]       prev_code;
   logic             legal;
   logic             change;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;
   logic             none;
   logic [IDX_W-1:0] idx;
   logic [EW-1:0]    entry;

   assign legal  = is_legal_code(bus.code_in);
   assign change = bus.in_en && legal && (bus.code_in != prev_code);
   assign pop    = bus.out_valid && bus.out_ready;
   assign push   = change && (!full || pop);
   assign drop   = change && full && !pop;
   assign none   = (bus.code_in == CODE_NONE);
   assign idx    = none ? IDX_W'(0) : bus.code_in[IDX_W-1:0];
   assign entry  = {none, idx, ts};

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (entry),
      .pop   (bus.out_ready),
      .rdata (bus.out_data),
      .valid (bus.out_valid),
      .full  (full),
      .count (count)
   );

   // A new drop or illegal sample outranks a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts        <= '0;
         prev_code <= CODE_NONE;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
         err       <= 1'b0;
      end else begin
         ts <= ts + TS_W'(1);
         if (change) begin
            prev_code <= bus.code_in;
         end
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr_flags ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
         end else if (clr_flags) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
         if (bus.in_en && !legal) begin
            err <= 1'b1;
         end else if (clr_flags) begin
            err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pe_code_capture.sv
// tb/tb_pe_code_capture.sv - scoreboard bench for pe_code_capture
module tb_pe_code_capture;
   import pe_pkg::*;

   logic       clk;
   logic       rst;
   logic       clr_flags;
   logic [3:0] count;
   logic       overflow;
   logic [7:0] drop_cnt;
   logic       err;

   pe_code_capture_if #(.TS_W(8)) bus ();

   pe_code_capture #(.DEPTH(8), .TS_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .count     (count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .err       (err),
      .clr_flags (clr_flags)
   );

   int         total;
   int         bad;
   entry_t     q[$];
   logic [7:0] mts;
   logic [7:0] mprev;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      bit     popping;
      bit     ev;
      entry_t e;
      popping = !rst && bus.out_ready && (q.size() > 0);
      ev = !rst && bus.in_en && ((bus.code_in <= 8'd15) || (bus.code_in == 8'hF0))
           && (bus.code_in != mprev);
      if (rst) begin
         q.delete();
         mprev = 8'hF0;
      end else begin
         if (popping) void'(q.pop_front());
         if (ev) begin
            mprev   = bus.code_in;
            e.none  = (bus.code_in == 8'hF0);
            e.idx   = e.none ? 4'd0 : bus.code_in[3:0];
            e.stamp = mts;
            if (q.size() < 8) q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      mts = rst ? 8'd0 : mts + 8'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr_flags = 1'b0; bus.in_en = 1'b0; bus.code_in = 8'hF0; bus.out_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", bus.out_valid); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %0h want 0", overflow); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0h want 0", err); end
      total++; if (bus.out_data !== 13'h0) begin bad++; $display("FAIL rst_data: got %0h want 0", bus.out_data); end
      bus.in_en = 1'b1; bus.code_in = 8'hF0;
      cyc();
      bus.in_en = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL none_no_push: got %0d want 0", count); end
   endtask

   task automatic test_first_event();
      cyc(); cyc();
      bus.in_en = 1'b1; bus.code_in = 8'd5;
      cyc();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %0h want 1", bus.out_valid); end
      total++; if (bus.out_data !== 13'h0503) begin bad++; $display("FAIL first_data: got %0h want 503", bus.out_data); end
      repeat (10) cyc();
      bus.in_en = 1'b0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL hold_count: got %0d want 1", count); end
      total++; if (bus.out_data !== 13'h0503) begin bad++; $display("FAIL hold_data: got %0h want 503", bus.out_data); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== q[0]) begin
            bad++; $display("FAIL drain1: got %0h want %0h", bus.out_data, q[0]);
         end
         cyc();
      end
      bus.out_ready = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL drain1_count: got %0d want 0", count); end
   endtask

   task automatic test_sequence();
      logic [7:0] s;
      bus.in_en = 1'b1; bus.code_in = 8'hF0;
      cyc();
      bus.in_en = 1'b0; bus.out_ready = 1'b1;
      total++; if (bus.out_data !== q[0]) begin bad++; $display("FAIL seq_pre: got %0h want %0h", bus.out_data, q[0]); end
      cyc();
      bus.out_ready = 1'b0; bus.in_en = 1'b1;
      s = mts;
      bus.code_in = 8'd5;  cyc();
      bus.code_in = 8'd9;  cyc();
      bus.code_in = 8'hF0; cyc();
      bus.in_en = 1'b0;
      total++; if (count !== 4'd3) begin bad++; $display("FAIL seq_count: got %0d want 3", count); end
      bus.out_ready = 1'b1;
      total++; if (bus.out_data !== {1'b0, 4'd5, s}) begin bad++; $display("FAIL seq_pop0: got %0h want %0h", bus.out_data, {1'b0, 4'd5, s}); end
      cyc();
      total++; if (bus.out_data !== {1'b0, 4'd9, s + 8'd1}) begin bad++; $display("FAIL seq_pop1: got %0h want %0h", bus.out_data, {1'b0, 4'd9, s + 8'd1}); end
      cyc();
      total++; if (bus.out_data !== {1'b1, 4'd0, s + 8'd2}) begin bad++; $display("FAIL seq_pop2: got %0h want %0h", bus.out_data, {1'b1, 4'd0, s + 8'd2}); end
      cyc();
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL seq_empty: got %0h want 0", bus.out_valid); end
   endtask

   task automatic test_overflow();
      bus.out_ready = 1'b0; bus.in_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.code_in = 8'(i);
         cyc();
      end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_fill: got %0d want 8", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0h want 0", overflow); end
      bus.code_in = 8'd8;
      cyc();
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0h want 1", overflow); end
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", count); end
      bus.out_ready = 1'b1; bus.code_in = 8'd9;
      cyc();
      bus.in_en = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_pushpop_count: got %0d want 8", count); end
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL full_pushpop_drop: got %0d want 1", drop_cnt); end
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== q[0]) begin
            bad++; $display("FAIL drain_ovf: got %0h want %0h", bus.out_data, q[0]);
         end
         cyc();
      end
      bus.out_ready = 1'b0;
      clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow: got %0h want 0", overflow); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL clr_drop: got %0d want 0", drop_cnt); end
   endtask

   task automatic test_err_wrap();
      int n;
      bus.in_en = 1'b1; bus.code_in = 8'h20;
      cyc();
      bus.in_en = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %0h want 1", err); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL err_no_push: got %0d want 0", count); end
      clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr: got %0h want 0", err); end
      bus.in_en = 1'b1; bus.code_in = 8'h33; clr_flags = 1'b1;
      cyc();
      bus.in_en = 1'b0; clr_flags = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_wins_clr: got %0h want 1", err); end
      clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
      n = 0;
      while (mts != 8'd0 && n < 300) begin
         cyc();
         n++;
      end
      total++; if (n >= 300) begin bad++; $display("FAIL wrap_wait: got %0d cycles want <300", n); end
      bus.in_en = 1'b1; bus.code_in = 8'd3;
      cyc();
      bus.in_en = 1'b0;
      total++; if (bus.out_data !== 13'h0300) begin bad++; $display("FAIL wrap_stamp: got %0h want 300", bus.out_data); end
      bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
      bus.in_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus.code_in = 8'(i);
         cyc();
      end
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL pre_clr_drop: got %0d want 1", drop_cnt); end
      bus.code_in = 8'd9; clr_flags = 1'b1;
      cyc();
      bus.in_en = 1'b0; clr_flags = 1'b0;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_wins_ovf: got %0h want 1", overflow); end
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_wins_cnt: got %0d want 1", drop_cnt); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== q[0]) begin
            bad++; $display("FAIL drain_wrap: got %0h want %0h", bus.out_data, q[0]);
         end
         cyc();
      end
      bus.out_ready = 1'b0;
      clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0; bus.in_en = 1'b1;
      for (int i = 10; i < 15; i++) begin
         bus.code_in = 8'(i);
         cyc();
      end
      bus.in_en = 1'b0;
      total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_fill: got %0d want 5", count); end
      rst = 1'b1; cyc(); rst = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", count); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0h want 0", bus.out_valid); end
      bus.in_en = 1'b1; bus.code_in = 8'hF0;
      cyc();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_prev_none: got %0d want 0", count); end
      bus.code_in = 8'd14;
      cyc();
      bus.in_en = 1'b0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL mid_repush: got %0d want 1", count); end
      total++; if (bus.out_data !== q[0]) begin bad++; $display("FAIL mid_data: got %0h want %0h", bus.out_data, q[0]); end
   endtask

   initial begin
      total = 0; bad = 0; mts = 8'd0; mprev = 8'hF0;
      rst = 1'b1; clr_flags = 1'b0;
      bus.code_in = 8'hF0; bus.in_en = 1'b0; bus.out_ready = 1'b0;
      test_reset();
      test_first_event();
      test_sequence();
      test_overflow();
      test_err_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
